// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches bytes over req/ack and hands them
// to the decoder over valid/ready, with jump/branch redirect.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;

  assign mem_addr = pc;
  assign pc_out   = pc;

  // mem_req / instr_valid are kept as flops that always track the state encoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= S_IDLE;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      mem_req     <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over ack (byte dropped) and over a completing handshake.
      pc          <= redirect_addr;
      state       <= en ? S_REQ : S_IDLE;
      mem_req     <= en;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state   <= S_REQ;
            mem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            instr       <= mem_rdata;
            instr_pc    <= pc;
            pc          <= pc + ADDR_W'(1);
            state       <= S_VALID;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            state       <= en ? S_REQ : S_IDLE;
            mem_req     <= en;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, wait/backpressure, wrap,
// redirect collision, enable drop and mid-operation reset.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mem_req;
  logic [5:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic [5:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [5:0] redirect_addr;
  logic [5:0] pc_out;

  int n_cmp = 0;
  int n_err = 0;
  bit auto_mem = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .pc_out        (pc_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; with auto_mem set, act as zero-wait memory returning A0+addr.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_ack   = mem_req;
      mem_rdata = 8'hA0 + {2'b00, mem_addr};
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 6'd0;

    // 1 reset
    step(); step();
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0; en = 1'b1;
    step();
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", 32'(mem_addr), 32'd0);

    // 2 zero-wait stream
    auto_mem = 1'b1; instr_ready = 1'b1;
    mem_ack = mem_req; mem_rdata = 8'hA0 + {2'b00, mem_addr};
    for (int i = 0; i < 3; i++) begin
      step();
      check("strm_valid", 32'(instr_valid), 32'd1);
      check("strm_instr", 32'(instr), 32'hA0 + 32'(i));
      check("strm_pc", 32'(instr_pc), 32'(i));
      step();
      check("strm_gap", 32'(instr_valid), 32'd0);
      check("strm_addr", 32'(mem_addr), 32'(i + 1));
    end

    // 3 memory wait then decoder backpressure
    auto_mem = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req", 32'(mem_req), 32'd1);
      check("wait_addr", 32'(mem_addr), 32'd3);
    end
    mem_ack = 1'b1; mem_rdata = 8'h5C;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_instr", 32'(instr), 32'h5C);
      check("bp_ipc", 32'(instr_pc), 32'd3);
      check("bp_pc", 32'(pc_out), 32'd4);
      step();
    end
    instr_ready = 1'b1;
    step();
    check("bp_done_addr", 32'(mem_addr), 32'd4);

    // 4 wrap at top of address space
    redirect = 1'b1; redirect_addr = 6'd63;
    step();
    redirect = 1'b0;
    check("wrap_addr63", 32'(mem_addr), 32'd63);
    mem_ack = 1'b1; mem_rdata = 8'hDF;
    step();
    mem_ack = 1'b0;
    check("wrap_ipc", 32'(instr_pc), 32'd63);
    check("wrap_instr", 32'(instr), 32'hDF);
    check("wrap_pc", 32'(pc_out), 32'd0);
    step();
    check("wrap_addr0", 32'(mem_addr), 32'd0);

    // 5 redirect collides with ack at pc=5
    redirect = 1'b1; redirect_addr = 6'd5;
    step();
    check("coll_addr5", 32'(mem_addr), 32'd5);
    redirect_addr = 6'd20; mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    redirect = 1'b0; mem_ack = 1'b0;
    check("coll_valid", 32'(instr_valid), 32'd0);
    check("coll_req", 32'(mem_req), 32'd1);
    check("coll_addr", 32'(mem_addr), 32'd20);
    check("coll_keep", 32'(instr), 32'hDF);
    mem_ack = 1'b1; mem_rdata = 8'h94;
    step();
    mem_ack = 1'b0;
    check("coll_ipc", 32'(instr_pc), 32'd20);
    check("coll_instr", 32'(instr), 32'h94);

    // 6 enable drop, stray ack in idle, then reset during S_VALID
    step();
    check("en_addr", 32'(mem_addr), 32'd21);
    en = 1'b0;
    step();
    check("en_req_held", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h15; instr_ready = 1'b0;
    step();
    mem_ack = 1'b0;
    check("en_valid", 32'(instr_valid), 32'd1);
    check("en_instr", 32'(instr), 32'h15);
    instr_ready = 1'b1;
    step();
    check("idle_valid", 32'(instr_valid), 32'd0);
    check("idle_req", 32'(mem_req), 32'd0);
    check("idle_pc", 32'(pc_out), 32'd22);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    step();
    mem_ack = 1'b0;
    check("stray_valid", 32'(instr_valid), 32'd0);
    check("stray_pc", 32'(pc_out), 32'd22);
    check("stray_instr", 32'(instr), 32'h15);
    en = 1'b1; instr_ready = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 8'h33;
    step();
    mem_ack = 1'b0;
    check("pre_rst_valid", 32'(instr_valid), 32'd1);
    check("pre_rst_ipc", 32'(instr_pc), 32'd22);
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_pc", 32'(pc_out), 32'd0);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_instr", 32'(instr), 32'd0);
    check("mid_rst_ipc", 32'(instr_pc), 32'd0);
    rst = 1'b0; en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
